// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Upstream stage of the NBBPU ALU. Holds the program counter and fetches
// 16-bit instructions over a req/ack handshake with instruction memory.
// Each fetched word is latched and offered to execute under valid/ready,
// together with its PC, PC+1 and the decoded register addresses. Execute may
// redirect the PC at any time; a redirect beats a same-cycle ack or ready.
//
// Optional feature (macro NBBPU_FETCH_HALT_EN):
//   Opcode 4'b1011 is treated as HALT. The fetch FSM parks in a HALT state:
//   no requests, no issue, redirects ignored, only reset exits. Without the
//   macro the opcode is issued like any other and `halted` is tied low.
//
// Parameters:
//   RESET_PC    PC value loaded on reset
//   ADDR_WIDTH  PC / memory address width (1..16)
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   synchronous, active-high reset
//   imem_req         out  fetch request (registered)
//   imem_addr        out  fetch address (= PC register)
//   imem_ack         in   memory returns data this cycle
//   imem_rdata       in   instruction word, valid with imem_ack
//   issue_valid      out  instruction outputs valid
//   issue_ready      in   execute consumes the instruction this cycle
//   instruction      out  latched instruction word
//   PC               out  address of latched instruction, zero-extended
//   PC_plus1         out  PC+1 modulo 2^ADDR_WIDTH, zero-extended
//   x_addr/y_addr/z_addr  out  instruction[11:8] / [7:4] / [3:0]
//   redirect         in   load a new PC (taken jump/branch)
//   redirect_target  in   new PC, low ADDR_WIDTH bits used
//   halted           out  fetch stopped (HALT feature only)
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [15:0]           imem_rdata,
    output logic                  issue_valid,
    input  logic                  issue_ready,
    output logic [15:0]           instruction,
    output logic [15:0]           PC,
    output logic [15:0]           PC_plus1,
    output logic [3:0]            x_addr,
    output logic [3:0]            y_addr,
    output logic [3:0]            z_addr,
    input  logic                  redirect,
    input  logic [15:0]           redirect_target,
    output logic                  halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
`ifdef NBBPU_FETCH_HALT_EN
        ,
        ST_HALT = 2'd3
`endif
    } state_t;

    localparam logic [3:0] HALT_OPCODE = 4'b1011;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [15:0]           r_instr;
    logic                  r_issue_valid;
    logic                  r_imem_req;

    state_t                w_state_d;
    logic [ADDR_WIDTH-1:0] w_pc_d;
    logic [15:0]           w_instr_d;
    logic [ADDR_WIDTH-1:0] w_pc_plus1;
    logic [ADDR_WIDTH-1:0] w_target;

    assign w_pc_plus1 = r_pc + ADDR_WIDTH'(1);
    assign w_target   = redirect_target[ADDR_WIDTH-1:0];

    // Next-state logic. Redirect wins over ack/ready in every active state;
    // in HOLD, redirect+ready consumes the held word but takes the target PC.
    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
        w_instr_d = r_instr;
        unique case (r_state)
            ST_IDLE: begin
                if (redirect) begin
                    w_pc_d = w_target;
                end
                w_state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redirect) begin
                    w_pc_d    = w_target;
                    w_state_d = ST_REQ;
                end else if (imem_ack) begin
                    w_instr_d = imem_rdata;
`ifdef NBBPU_FETCH_HALT_EN
                    if (imem_rdata[15:12] == HALT_OPCODE) begin
                        w_state_d = ST_HALT;
                    end else begin
                        w_state_d = ST_HOLD;
                    end
`else
                    w_state_d = ST_HOLD;
`endif
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    w_pc_d    = w_target;
                    w_state_d = ST_REQ;
                end else if (issue_ready) begin
                    w_pc_d    = w_pc_plus1;
                    w_state_d = ST_REQ;
                end
            end
`ifdef NBBPU_FETCH_HALT_EN
            ST_HALT: begin
                w_state_d = ST_HALT;
            end
`endif
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs are registered from the next state so they align
    // with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC[ADDR_WIDTH-1:0];
            r_instr       <= 16'h0000;
            r_issue_valid <= 1'b0;
            r_imem_req    <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_pc          <= w_pc_d;
            r_instr       <= w_instr_d;
            r_issue_valid <= (w_state_d == ST_HOLD);
            r_imem_req    <= (w_state_d == ST_REQ);
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign issue_valid = r_issue_valid;
    assign instruction = r_instr;
    assign PC          = 16'(r_pc);
    assign PC_plus1    = 16'(w_pc_plus1);
    assign x_addr      = r_instr[11:8];
    assign y_addr      = r_instr[7:4];
    assign z_addr      = r_instr[3:0];

`ifdef NBBPU_FETCH_HALT_EN
    assign halted = (r_state == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
